// File: rtl/spi_seq_pkg.sv
// Shared types and default constants for the SPI transaction sequencer.
//   seq_state_t    : sequencer FSM state encoding
//   SEQ_*          : default timing / depth values matching SPI_Controller defaults
package spi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        XFER,
        GAP
    } seq_state_t;

    // One XFER must outlast the controller's shift (send + receive + pause + margin).
    localparam int SEQ_TXN_CYCLES = 48;
    // Idle cycles after a transaction so start_comm shows a fresh rising edge.
    localparam int SEQ_GAP_CYCLES = 2;
    localparam int SEQ_DEPTH      = 4;

endpackage

// File: rtl/spi_req_fifo.sv
// Synchronous request FIFO holding {cs, data} words for the sequencer.
//   clk, rst             : clock, asynchronous active-low reset
//   push, push_data      : write request (ignored when full)
//   pop                  : read request (ignored when empty)
//   head                 : entry at the read pointer (valid when !empty)
//   full, empty, count   : occupancy status
module spi_req_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Transaction sequencer in front of SPI_Controller. Queues requests, launches
// one controller transaction at a time, waits a fixed transfer time, then
// captures CIPO_register into a valid/ready response register.
//   clk, rst                        : clock, asynchronous active-low reset
//   req_valid/req_ready/req_data/req_cs : request push interface
//   rsp_valid/rsp_ready/rsp_data/rsp_cs : captured response interface
//   busy                            : FSM active or requests pending
//   start_comm, data_send, CS_in    : controller drive (registered)
//   CIPO_register                   : controller receive register
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int LENGTH_SEND      = 16,
    parameter int LENGTH_RECEIVED  = 16,
    parameter int PERIPHERY_SELECT = 2,
    parameter int DEPTH            = SEQ_DEPTH,
    parameter int TXN_CYCLES       = SEQ_TXN_CYCLES,
    parameter int GAP_CYCLES       = SEQ_GAP_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [LENGTH_SEND-1:0]      req_data,
    input  logic [PERIPHERY_SELECT-1:0] req_cs,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [LENGTH_RECEIVED-1:0]  rsp_data,
    output logic [PERIPHERY_SELECT-1:0] rsp_cs,
    output logic                        busy,
    output logic                        start_comm,
    output logic [LENGTH_SEND-1:0]      data_send,
    output logic [PERIPHERY_SELECT-1:0] CS_in,
    input  logic [LENGTH_RECEIVED-1:0]  CIPO_register
);

    localparam int TXN_W  = $clog2(TXN_CYCLES);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int FIFO_W = PERIPHERY_SELECT + LENGTH_SEND;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    seq_state_t state;
    seq_state_t next_state;

    logic [TXN_W-1:0]            xfer_cnt;
    logic [GAP_W-1:0]            gap_cnt;
    logic [PERIPHERY_SELECT-1:0] cs_shadow;

    logic [FIFO_W-1:0]           fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_push;

    logic slot_free;
    logic launch;
    logic capture;
    logic xfer_load;
    logic start_next;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;

    spi_req_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({req_cs, req_data}),
        .pop       (launch),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy = (state != IDLE) || (fifo_count != '0);

    // A launch only happens once the response slot will be empty, so a
    // capture can never collide with an unconsumed response.
    assign slot_free = !rsp_valid || rsp_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty && slot_free) next_state = LAUNCH;
            LAUNCH:  next_state = XFER;
            XFER:    if (xfer_cnt == '0) next_state = GAP;
            GAP:     if (gap_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (feeds the registered outputs below)
    // ------------------------------------------------------------------
    always_comb begin
        launch     = 1'b0;
        capture    = 1'b0;
        xfer_load  = 1'b0;
        start_next = 1'b0;
        case (state)
            IDLE:    launch    = (next_state == LAUNCH);
            LAUNCH:  xfer_load = 1'b1;
            XFER:    capture   = (xfer_cnt == '0);
            default: ;
        endcase
        start_next = (next_state == LAUNCH);
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (xfer_load)
                xfer_cnt <= TXN_W'(TXN_CYCLES - 1);
            else if (state == XFER && xfer_cnt != '0)
                xfer_cnt <= xfer_cnt - TXN_W'(1);

            if (capture)
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Controller drive and response register
    // ------------------------------------------------------------------
    // data_send/CS_in hold until the next launch: the controller samples
    // data_send on a later negedge, well after start_comm has risen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_comm <= 1'b0;
            data_send  <= '0;
            CS_in      <= '0;
            cs_shadow  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_cs     <= '0;
        end else begin
            start_comm <= start_next;
            if (launch) begin
                data_send <= fifo_head[LENGTH_SEND-1:0];
                CS_in     <= fifo_head[FIFO_W-1:LENGTH_SEND];
                cs_shadow <= fifo_head[FIFO_W-1:LENGTH_SEND];
            end
            if (capture) begin
                rsp_data  <= CIPO_register;
                rsp_cs    <= cs_shadow;
                rsp_valid <= 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
module tb_spi_txn_sequencer;
    import spi_seq_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  cs;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [1:0]  req_cs = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_cs;
    logic        busy;
    logic        start_comm;
    logic [15:0] data_send;
    logic [1:0]  CS_in;
    logic [15:0] CIPO_register;

    // Peripheral model: echoes data_send ^ 5A5A unless a fixed value is forced.
    logic        cipo_force = 1'b0;
    logic [15:0] cipo_val = '0;
    assign CIPO_register = cipo_force ? cipo_val : (data_send ^ 16'h5A5A);

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_count = 0;
    int rsp_rise_cyc = 0;

    txn_t rsp_q[$];
    txn_t lau_q[$];
    int   launch_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_txn_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_cs        (req_cs),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_cs        (rsp_cs),
        .busy          (busy),
        .start_comm    (start_comm),
        .data_send     (data_send),
        .CS_in         (CS_in),
        .CIPO_register (CIPO_register)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] prev_ds = '0;
    logic [1:0]  prev_csin = '0;
    logic [15:0] prev_rd = '0;
    logic [1:0]  prev_rcs = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (start_comm) begin
                check("start_comm one cycle", {31'd0, prev_start}, 32'd0);
                launch_cyc.push_back(cyc);
                if (lau_q.size() == 0) begin
                    check("unexpected launch", 32'd1, 32'd0);
                end else begin
                    txn_t e;
                    e = lau_q.pop_front();
                    check("launch data_send", {16'd0, data_send}, {16'd0, e.data});
                    check("launch CS_in", {30'd0, CS_in}, {30'd0, e.cs});
                end
            end else begin
                check("data_send held", {16'd0, data_send}, {16'd0, prev_ds});
                check("CS_in held", {30'd0, CS_in}, {30'd0, prev_csin});
            end
            if (prev_valid && !prev_hs) begin
                check("rsp_data not overwritten", {16'd0, rsp_data}, {16'd0, prev_rd});
                check("rsp_cs not overwritten", {30'd0, rsp_cs}, {30'd0, prev_rcs});
            end
            if (rsp_valid && !prev_valid) rsp_rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (rsp_q.size() == 0) begin
                    check("unexpected response", 32'd1, 32'd0);
                end else begin
                    txn_t e;
                    e = rsp_q.pop_front();
                    check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                    check("rsp_cs", {30'd0, rsp_cs}, {30'd0, e.cs});
                end
            end
            if (dut.state == XFER && dut.xfer_cnt == '0) begin
                total++;
                assert (!rsp_valid) else begin
                    bad++;
                    $display("FAIL same-edge capture: rsp_valid=%0b required 0", rsp_valid);
                end
            end
        end
        prev_start = rst && start_comm;
        prev_valid = rst && rsp_valid;
        prev_hs    = rst && rsp_valid && rsp_ready;
        prev_ds    = data_send;
        prev_csin  = CS_in;
        prev_rd    = rsp_data;
        prev_rcs   = rsp_cs;
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic push(input logic [15:0] d, input logic [1:0] cs,
                        input logic [15:0] exp_rsp, output int k);
        int  n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        req_valid = 1'b1;
        req_data  = d;
        req_cs    = cs;
        do begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 400);
        req_valid = 1'b0;
        k = cyc;
        if (!rdy) begin
            check("push accepted before timeout", 32'd0, 32'd1);
            k = -1;
        end else begin
            rsp_q.push_back('{data: exp_rsp, cs: cs});
            lau_q.push_back('{data: d, cs: cs});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || busy || rsp_valid) && n < 2000) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, n < 2000}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " rsp_data"}, {16'd0, rsp_data}, 32'd0);
        check({tag, " rsp_cs"}, {30'd0, rsp_cs}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " start_comm"}, {31'd0, start_comm}, 32'd0);
        check({tag, " data_send"}, {16'd0, data_send}, 32'd0);
        check({tag, " CS_in"}, {30'd0, CS_in}, 32'd0);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k, j, idx, nrsp, nlau, n;
        logic [15:0] wdata [9];

        #1 rst = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b1;

        // Single write, accepted at edge 10.
        while (cyc < 9) tick(1);
        push(16'hA5C3, 2'd1, 16'hFF99, k);
        check("accept edge", k, 10);
        tick(1);
        check("t1 start_comm at k+1", {31'd0, start_comm}, 32'd1);
        check("t1 data_send", {16'd0, data_send}, 32'h0000A5C3);
        check("t1 CS_in", {30'd0, CS_in}, 32'd1);
        tick(1);
        check("t1 start_comm low at k+2", {31'd0, start_comm}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 100) begin tick(1); n++; end
        check("t1 rsp_valid edge", cyc, k + 50);
        check("t1 data_send held through xfer", {16'd0, data_send}, 32'h0000A5C3);
        wait_drain("t1 drain");

        // Loopback read with a fixed CIPO value.
        cipo_force = 1'b1;
        cipo_val   = 16'h1234;
        push(16'h0F0F, 2'd2, 16'h1234, k);
        wait_drain("t2 drain");
        cipo_force = 1'b0;

        // FIFO fill behind a stalled response, then release.
        rsp_ready = 1'b0;
        push(16'h1111, 2'd0, 16'h4B4B, k);
        n = 0;
        while (!rsp_valid && n < 100) begin tick(1); n++; end
        check("t3 first rsp held", {31'd0, rsp_valid}, 32'd1);
        push(16'h2222, 2'd1, 16'h7878, k);
        push(16'h3333, 2'd2, 16'h6969, k);
        push(16'h4444, 2'd3, 16'h1E1E, k);
        push(16'h5555, 2'd0, 16'h0F0F, k);
        check("t3 req_ready low when full", {31'd0, req_ready}, 32'd0);
        check("t3 busy when full", {31'd0, busy}, 32'd1);
        nlau = launch_cyc.size();
        req_valid = 1'b1;
        req_data  = 16'h6666;
        req_cs    = 2'd1;
        tick(60);
        check("t3 no launch under back-pressure", launch_cyc.size(), nlau);
        check("t3 rsp_data unchanged", {16'd0, rsp_data}, 32'h00004B4B);
        check("t3 fifth push refused", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        idx = launch_cyc.size();
        tick(1);
        check("t3 launch right after release", {31'd0, start_comm}, 32'd1);
        push(16'h6666, 2'd1, 16'h3C3C, j);
        wait_drain("t3 drain");
        check("t3 launches after release", launch_cyc.size() - idx, 5);
        if (launch_cyc.size() - idx == 5) begin
            for (int i = 1; i < 5; i++)
                check("t3 launch period", launch_cyc[idx + i] - launch_cyc[idx + i - 1], 52);
        end

        // Reset in the middle of XFER (counter at 20).
        push(16'hABCD, 2'd3, 16'hF197, k);
        while (cyc < k + 29) tick(1);
        check("t4 in xfer before reset", {31'd0, dut.state == XFER}, 32'd1);
        #2 rst = 1'b0;
        #1;
        rsp_q.delete();
        lau_q.delete();
        check_idle_outputs("mid-reset");
        tick(2);
        rst = 1'b1;
        nrsp = rsp_count;
        nlau = launch_cyc.size();
        tick(80);
        check("t4 no rsp after reset", rsp_count, nrsp);
        check("t4 rsp_valid stays low", {31'd0, rsp_valid}, 32'd0);
        check("t4 no launch after reset", launch_cyc.size(), nlau);

        // Wrap-around: nine transactions through the 4-deep FIFO.
        wdata = '{16'h0001, 16'h1357, 16'h2468, 16'h8000, 16'hFFFF,
                  16'h00FF, 16'hC0DE, 16'hBEEF, 16'h7E57};
        nrsp = rsp_count;
        for (int i = 0; i < 9; i++)
            push(wdata[i], 2'(i), wdata[i] ^ 16'h5A5A, k);
        wait_drain("t5 drain");
        check("t5 responses", rsp_count - nrsp, 9);
        check("scoreboard empty", rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
